ines_rom_loader: RTL and testbench

//  Consumes the SoC game_rom conduit (NIOS byte-writes of a .nes image, rom_addr = file offset).

---
 rtl/ines_rom_loader.sv | 179 +++++++++++++++++
 tb/tb_ines_rom_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ines_rom_loader.sv
// ines_rom_loader
//   Sits on the SoC game_rom conduit and turns NIOS byte writes of a .nes
//   image (rom_addr = file offset) into PRG/CHR RAM writes. The 16-byte iNES
//   header is captured and validated. Written bytes can be read back, and the
//   NES core is held in reset until the whole image has been loaded.
// Ports
//   clk, reset_n                 system clock, async active-low reset
//   to_game_rom / from_game_rom  conduit write data / readback data
//   write_rom / read_rom         level strobes, one access per rising edge
//   rom_addr                     file byte offset
//   prg_addr/wdata/we/rdata      PRG RAM port B (sync read, 1-cycle latency)
//   chr_addr/wdata/we/rdata      CHR RAM port B (sync read, 1-cycle latency)
//   prg_banks, chr_banks, mapper, mirroring   decoded header fields
//   header_valid, load_done, load_err         load status
//   nes_reset_n                  released once load_done & ~load_err
module ines_rom_loader #(
  parameter int unsigned PRG_AW = 15,
  parameter int unsigned CHR_AW = 13
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        to_game_rom,
  output logic [7:0]        from_game_rom,
  input  logic              write_rom,
  input  logic              read_rom,
  input  logic [15:0]       rom_addr,
  output logic [PRG_AW-1:0] prg_addr,
  output logic [7:0]        prg_wdata,
  output logic              prg_we,
  input  logic [7:0]        prg_rdata,
  output logic [CHR_AW-1:0] chr_addr,
  output logic [7:0]        chr_wdata,
  output logic              chr_we,
  input  logic [7:0]        chr_rdata,
  output logic [7:0]        prg_banks,
  output logic [7:0]        chr_banks,
  output logic [7:0]        mapper,
  output logic              mirroring,
  output logic              header_valid,
  output logic              load_done,
  output logic              load_err,
  output logic              nes_reset_n
);

  typedef enum logic [1:0] {ST_HEADER, ST_PAYLOAD, ST_DONE, ST_ERROR} state_t;

  localparam logic [23:0] PRG_CAP = 24'd1 << PRG_AW;
  localparam logic [23:0] CHR_CAP = 24'd1 << CHR_AW;

  state_t      state;
  logic [7:0]  hdr [16];
  logic        write_q, read_q;
  logic        wr_ev, rd_ev;
  logic [23:0] p, prg_sz, chr_sz, tot;
  logic        hdr_ok;
  // Two-stage read pipeline: stage 1 = address on the RAM port,
  // stage 2 = RAM data valid and captured into from_game_rom.
  logic        rd_v1, rd_v2, rd_sel1, rd_sel2;

  assign wr_ev = write_rom & ~write_q;
  assign rd_ev = read_rom & ~read_q & ~wr_ev;

  assign p      = {8'd0, rom_addr} - 24'd16;
  assign prg_sz = {2'd0, hdr[4], 14'd0};
  assign chr_sz = {3'd0, hdr[5], 13'd0};
  assign tot    = prg_sz + chr_sz;

  assign hdr_ok = (hdr[0] == 8'h4E) && (hdr[1] == 8'h45) && (hdr[2] == 8'h53) &&
                  (hdr[3] == 8'h1A) && (hdr[4] != 8'd0) &&
                  (prg_sz <= PRG_CAP) && (chr_sz <= CHR_CAP);

  assign prg_banks   = hdr[4];
  assign chr_banks   = hdr[5];
  assign mapper      = {hdr[7][7:4], hdr[6][7:4]};
  assign mirroring   = hdr[6][0];
  assign nes_reset_n = load_done & ~load_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_HEADER;
      write_q       <= 1'b0;
      read_q        <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) hdr[i] <= '0;
      header_valid  <= 1'b0;
      load_done     <= 1'b0;
      load_err      <= 1'b0;
      prg_addr      <= '0;
      prg_wdata     <= '0;
      prg_we        <= 1'b0;
      chr_addr      <= '0;
      chr_wdata     <= '0;
      chr_we        <= 1'b0;
      from_game_rom <= '0;
      rd_v1         <= 1'b0;
      rd_v2         <= 1'b0;
      rd_sel1       <= 1'b0;
      rd_sel2       <= 1'b0;
    end else begin
      write_q <= write_rom;
      read_q  <= read_rom;
      prg_we  <= 1'b0;
      chr_we  <= 1'b0;
      rd_v1   <= 1'b0;
      rd_v2   <= rd_v1;
      rd_sel2 <= rd_sel1;

      if (rd_v2) from_game_rom <= rd_sel2 ? chr_rdata : prg_rdata;

      if (wr_ev) begin
        if (rom_addr == 16'd0) begin
          // Offset 0 always restarts the load, whatever the current state.
          hdr[0]       <= to_game_rom;
          header_valid <= 1'b0;
          load_done    <= 1'b0;
          load_err     <= 1'b0;
          state        <= ST_HEADER;
        end else begin
          unique case (state)
            ST_HEADER: begin
              if (rom_addr < 16'd16) begin
                hdr[rom_addr[3:0]] <= to_game_rom;
                // Byte 15 is not part of the checked fields, so the
                // stored bytes 0..5 are already final here.
                if (rom_addr == 16'd15) begin
                  if (hdr_ok) begin
                    header_valid <= 1'b1;
                    state        <= ST_PAYLOAD;
                  end else begin
                    load_err <= 1'b1;
                    state    <= ST_ERROR;
                  end
                end
              end else begin
                load_err <= 1'b1;
                state    <= ST_ERROR;
              end
            end
            ST_PAYLOAD, ST_DONE: begin
              if (rom_addr >= 16'd16) begin
                if (p < prg_sz) begin
                  prg_addr  <= PRG_AW'(p);
                  prg_wdata <= to_game_rom;
                  prg_we    <= 1'b1;
                end else if (p < tot) begin
                  chr_addr  <= CHR_AW'(p - prg_sz);
                  chr_wdata <= to_game_rom;
                  chr_we    <= 1'b1;
                end else begin
                  load_err <= 1'b1;
                  state    <= ST_ERROR;
                end
                if (p == tot - 24'd1) begin
                  load_done <= 1'b1;
                  state     <= ST_DONE;
                end
              end
            end
            ST_ERROR: ;
          endcase
        end
      end else if (rd_ev) begin
        if (rom_addr < 16'd16) begin
          from_game_rom <= hdr[rom_addr[3:0]];
        end else if (header_valid && (p < prg_sz)) begin
          prg_addr <= PRG_AW'(p);
          rd_v1    <= 1'b1;
          rd_sel1  <= 1'b0;
        end else if (header_valid && (p < tot)) begin
          chr_addr <= CHR_AW'(p - prg_sz);
          rd_v1    <= 1'b1;
          rd_sel1  <= 1'b1;
        end else begin
          from_game_rom <= 8'hFF;
        end
      end
    end
  end

endmodule

// File: tb/tb_ines_rom_loader.sv
// tb_ines_rom_loader
//   Directed bench for ines_rom_loader with PRG_AW=15 / CHR_AW=13. Inputs are
//   driven and outputs sampled on the falling edge; PRG/CHR RAMs are modelled
//   as synchronous RAMs with a one-cycle read latency.
module tb_ines_rom_loader;

  logic        clk;
  logic        reset_n;
  logic [7:0]  to_game_rom;
  logic [7:0]  from_game_rom;
  logic        write_rom;
  logic        read_rom;
  logic [15:0] rom_addr;
  logic [14:0] prg_addr;
  logic [7:0]  prg_wdata;
  logic        prg_we;
  logic [7:0]  prg_rdata;
  logic [12:0] chr_addr;
  logic [7:0]  chr_wdata;
  logic        chr_we;
  logic [7:0]  chr_rdata;
  logic [7:0]  prg_banks;
  logic [7:0]  chr_banks;
  logic [7:0]  mapper;
  logic        mirroring;
  logic        header_valid;
  logic        load_done;
  logic        load_err;
  logic        nes_reset_n;

  int checks = 0;
  int errors = 0;

  ines_rom_loader #(.PRG_AW(15), .CHR_AW(13)) dut (
    .clk(clk), .reset_n(reset_n),
    .to_game_rom(to_game_rom), .from_game_rom(from_game_rom),
    .write_rom(write_rom), .read_rom(read_rom), .rom_addr(rom_addr),
    .prg_addr(prg_addr), .prg_wdata(prg_wdata), .prg_we(prg_we), .prg_rdata(prg_rdata),
    .chr_addr(chr_addr), .chr_wdata(chr_wdata), .chr_we(chr_we), .chr_rdata(chr_rdata),
    .prg_banks(prg_banks), .chr_banks(chr_banks), .mapper(mapper), .mirroring(mirroring),
    .header_valid(header_valid), .load_done(load_done), .load_err(load_err),
    .nes_reset_n(nes_reset_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] prg_mem [32768];
  logic [7:0] chr_mem [8192];
  always @(posedge clk) begin
    if (prg_we) prg_mem[prg_addr] <= prg_wdata;
    if (chr_we) chr_mem[chr_addr] <= chr_wdata;
    prg_rdata <= prg_mem[prg_addr];
    chr_rdata <= chr_mem[chr_addr];
  end

  // Values captured by wr(): the cycle after the strobe edge and the one after.
  logic        s_prg_we, s_chr_we, s_prg_we2, s_chr_we2;
  logic [14:0] s_prg_addr;
  logic [12:0] s_chr_addr;
  logic [7:0]  s_prg_wdata, s_chr_wdata;
  // from_game_rom sampled 1, 2 and 3 cycles after a read strobe edge.
  logic [7:0]  r1, r2, r3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    rom_addr = a; to_game_rom = d; write_rom = 1'b1;
    @(negedge clk);
    s_prg_we = prg_we; s_prg_addr = prg_addr; s_prg_wdata = prg_wdata;
    s_chr_we = chr_we; s_chr_addr = chr_addr; s_chr_wdata = chr_wdata;
    write_rom = 1'b0;
    @(negedge clk);
    s_prg_we2 = prg_we; s_chr_we2 = chr_we;
  endtask

  task automatic rd(input logic [15:0] a);
    @(negedge clk);
    rom_addr = a; read_rom = 1'b1;
    @(negedge clk); r1 = from_game_rom; read_rom = 1'b0;
    @(negedge clk); r2 = from_game_rom;
    @(negedge clk); r3 = from_game_rom;
  endtask

  task automatic wr_hdr(input logic [7:0] b0, input logic [7:0] b4,
                        input logic [7:0] b6, input logic [7:0] b7);
    logic [7:0] h [16];
    for (int i = 0; i < 16; i++) h[i] = 8'h00;
    h[0] = b0; h[1] = 8'h45; h[2] = 8'h53; h[3] = 8'h1A;
    h[4] = b4; h[5] = 8'h01; h[6] = b6;    h[7] = b7;
    for (int i = 0; i < 16; i++) wr(16'(i), h[i]);
  endtask

  initial begin
    int cnt;
    reset_n = 1'b0; write_rom = 1'b0; read_rom = 1'b0;
    rom_addr = '0; to_game_rom = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_header_valid", 32'(header_valid), 32'h0);
    chk("rst_load_done", 32'(load_done), 32'h0);
    chk("rst_load_err", 32'(load_err), 32'h0);
    chk("rst_nes_reset_n", 32'(nes_reset_n), 32'h0);
    chk("rst_prg_we", 32'(prg_we), 32'h0);
    chk("rst_from_game_rom", 32'(from_game_rom), 32'h0);
    chk("rst_prg_banks", 32'(prg_banks), 32'h0);
    reset_n = 1'b1;

    // 1: NROM header
    wr_hdr(8'h4E, 8'h02, 8'h01, 8'h00);
    chk("t1_header_valid", 32'(header_valid), 32'h1);
    chk("t1_mirroring", 32'(mirroring), 32'h1);
    chk("t1_mapper", 32'(mapper), 32'h0);
    chk("t1_prg_banks", 32'(prg_banks), 32'h2);
    chk("t1_chr_banks", 32'(chr_banks), 32'h1);
    chk("t1_load_err", 32'(load_err), 32'h0);

    // 2: payload routing; total = 32768 + 8192 = 40960 bytes
    wr(16'd16, 8'hA5);
    chk("t2_prg_we0", 32'(s_prg_we), 32'h1);
    chk("t2_prg_addr0", 32'(s_prg_addr), 32'h0);
    chk("t2_prg_wdata0", 32'(s_prg_wdata), 32'hA5);
    chk("t2_chr_we0", 32'(s_chr_we), 32'h0);
    chk("t2_prg_we_pulse", 32'(s_prg_we2), 32'h0);
    chk("t2_done_early", 32'(load_done), 32'h0);
    wr(16'd32783, 8'h3C);
    chk("t2_prg_we1", 32'(s_prg_we), 32'h1);
    chk("t2_prg_addr1", 32'(s_prg_addr), 32'h7FFF);
    chk("t2_nes_rst_early", 32'(nes_reset_n), 32'h0);
    wr(16'd32784, 8'h42);
    chk("t2_chr_we_first", 32'(s_chr_we), 32'h1);
    chk("t2_chr_addr_first", 32'(s_chr_addr), 32'h0);
    chk("t2_prg_we_first", 32'(s_prg_we), 32'h0);
    chk("t2_done_mid", 32'(load_done), 32'h0);
    wr(16'd40975, 8'h77);
    chk("t2_chr_we_last", 32'(s_chr_we), 32'h1);
    chk("t2_chr_addr_last", 32'(s_chr_addr), 32'h1FFF);
    chk("t2_chr_wdata_last", 32'(s_chr_wdata), 32'h77);
    chk("t2_load_done", 32'(load_done), 32'h1);
    chk("t2_nes_reset_n", 32'(nes_reset_n), 32'h1);

    // 5: readback
    rd(16'd16);
    chk("t5_prg_hold", 32'(r2), 32'h0);
    chk("t5_prg_rd", 32'(r3), 32'hA5);
    rd(16'd4);
    chk("t5_hdr_rd", 32'(r1), 32'h02);
    rd(16'd50000);
    chk("t5_unmapped_rd", 32'(r3), 32'hFF);
    rd(16'd40975);
    chk("t5_chr_hold", 32'(r2), 32'hFF);
    chk("t5_chr_rd", 32'(r3), 32'h77);
    rd(16'd32784);
    chk("t5_chr_first_rd", 32'(r3), 32'h42);

    // 6: write strobe held high for 10 cycles -> one write
    @(negedge clk);
    rom_addr = 16'd17; to_game_rom = 8'h11; write_rom = 1'b1;
    cnt = 0;
    repeat (10) begin @(negedge clk); if (prg_we) cnt++; end
    write_rom = 1'b0;
    repeat (2) begin @(negedge clk); if (prg_we) cnt++; end
    chk("t6_single_we", 32'(cnt), 32'd1);
    rd(16'd17);
    chk("t6_done_write_lands", 32'(r3), 32'h11);

    // Past the end of the image -> error, no RAM write
    wr(16'd40976, 8'h99);
    chk("end_err", 32'(load_err), 32'h1);
    chk("end_chr_we", 32'(s_chr_we), 32'h0);
    chk("end_nes_reset_n", 32'(nes_reset_n), 32'h0);

    // 3: bad magic
    wr_hdr(8'h4F, 8'h02, 8'h01, 8'h00);
    chk("t3_load_err", 32'(load_err), 32'h1);
    chk("t3_header_valid", 32'(header_valid), 32'h0);
    chk("t3_load_done_cleared", 32'(load_done), 32'h0);
    wr(16'd16, 8'h12);
    chk("t3_no_prg_we", 32'(s_prg_we), 32'h0);
    wr(16'd40975, 8'h34);
    chk("t3_no_chr_we", 32'(s_chr_we), 32'h0);
    wr(16'd0, 8'h4E);
    chk("t3_restart_clears", 32'(load_err), 32'h0);

    // 4: oversize PRG, then premature payload write
    wr_hdr(8'h4E, 8'h03, 8'h01, 8'h00);
    chk("t4_prg3_err", 32'(load_err), 32'h1);
    wr(16'd0, 8'h4E);
    wr(16'd1, 8'h45);
    wr(16'd16, 8'h56);
    chk("t4_early_err", 32'(load_err), 32'h1);
    chk("t4_early_dropped", 32'(s_prg_we), 32'h0);

    // Valid header with mapper bits, then async reset mid-payload
    wr_hdr(8'h4E, 8'h02, 8'h10, 8'h20);
    chk("hv2_header_valid", 32'(header_valid), 32'h1);
    chk("hv2_mapper", 32'(mapper), 32'h21);
    chk("hv2_mirroring", 32'(mirroring), 32'h0);
    wr(16'd20, 8'h5A);
    chk("hv2_prg_addr", 32'(s_prg_addr), 32'h4);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_header_valid", 32'(header_valid), 32'h0);
    chk("ar_prg_banks", 32'(prg_banks), 32'h0);
    chk("ar_mapper", 32'(mapper), 32'h0);
    chk("ar_prg_addr", 32'(prg_addr), 32'h0);
    chk("ar_from_game_rom", 32'(from_game_rom), 32'h0);
    chk("ar_nes_reset_n", 32'(nes_reset_n), 32'h0);
    #10 reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
